conv_window_addr_gen: RTL and testbench

CONV_WINDOW_ADDR_GEN -- requirements
Module: conv_window_addr_gen

---
 rtl/conv_pkg.sv | 19 +
 rtl/window_pos_counter.sv | 50 +++++
 rtl/conv_window_addr_gen.sv | 150 +++++++++++++++
 tb/tb_conv_window_addr_gen.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and geometry helpers for the convolution window address generator.
package conv_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, STEP, FIN} state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Centre offset of window (0,0): padded scans centre on pixel 0, unpadded on pixel H.
  function automatic int calc_off(input int k, input bit pad);
    return pad ? 0 : (k - 1) / 2;
  endfunction

  function automatic int calc_out(input int img, input int k, input int s, input bit pad);
    return pad ? (img + s - 1) / s : (img - k) / s + 1;
  endfunction

endpackage

// File: rtl/window_pos_counter.sv
// Raster scan of the (r,c) output position; c is the fast index.
module window_pos_counter #(
  parameter int OUT_W = 26,
  parameter int OUT_H = 26,
  parameter int RW    = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          adv,
  output logic [RW-1:0] r,
  output logic [RW-1:0] c,
  output logic          last_c,
  output logic          last_r
);

  logic [RW-1:0] r_q, r_d, c_q, c_d;

  assign last_c = (c_q == RW'(OUT_W - 1));
  assign last_r = (r_q == RW'(OUT_H - 1));
  assign r      = r_q;
  assign c      = c_q;

  always_comb begin
    r_d = r_q;
    c_d = c_q;
    if (clr) begin
      r_d = '0;
      c_d = '0;
    end else if (adv) begin
      if (last_c) begin
        c_d = '0;
        if (!last_r) r_d = r_q + RW'(1);
      end else begin
        c_d = c_q + RW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q <= '0;
      c_q <= '0;
    end else begin
      r_q <= r_d;
      c_q <= c_d;
    end
  end

endmodule

// File: rtl/conv_window_addr_gen.sv
// KxK convolution window pixel-address generator, column-major beats with valid/ready.
// Define CONV_ZERO_PAD_EN for a same-size padded scan; otherwise windows stay inside the image.
module conv_window_addr_gen
  import conv_pkg::*;
#(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int K      = 3,
  parameter int STRIDE = 1,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_pad,
  output logic              win_first,
  output logic              win_last,
  output logic              win_full
);

`ifdef CONV_ZERO_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  localparam int H     = (K - 1) / 2;
  localparam int OFF   = calc_off(K, PAD_EN);
  localparam int OUT_W = calc_out(IMG_W, K, STRIDE, PAD_EN);
  localparam int OUT_H = calc_out(IMG_H, K, STRIDE, PAD_EN);
  localparam int NS    = (STRIDE < K) ? STRIDE : K;
  localparam int CW    = $clog2(max2(IMG_W, IMG_H) + K) + 2;
  localparam int RW    = $clog2(max2(OUT_W, OUT_H) + 1);
  localparam int KW    = $clog2(K);

  state_e        state_q, state_d;
  logic [KW-1:0] kr_q, kr_d, kc_q, kc_d;
  logic          busy_q, busy_d, done_q, done_d;
  logic          clr, adv, last_c, last_r;
  logic [RW-1:0] r, c;

  window_pos_counter #(.OUT_W(OUT_W), .OUT_H(OUT_H), .RW(RW)) u_pos (
    .clk(clk), .rst(rst), .clr(clr), .adv(adv),
    .r(r), .c(c), .last_c(last_c), .last_r(last_r)
  );

  logic fire, beat_last;
  logic [KW-1:0] kc_start;

  assign addr_valid = (state_q == LOAD) || (state_q == STEP);
  assign fire       = addr_valid && addr_ready;
  assign beat_last  = (kr_q == KW'(K - 1)) && (kc_q == KW'(K - 1));
  // Incremental windows only fetch the columns that slid into view.
  assign kc_start   = (state_q == LOAD) ? '0 : KW'(K - NS);

  always_comb begin
    state_d = state_q;
    kr_d    = kr_q;
    kc_d    = kc_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    clr     = 1'b0;
    adv     = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = LOAD;
        kr_d    = '0;
        kc_d    = '0;
        busy_d  = 1'b1;
        clr     = 1'b1;
      end
      LOAD, STEP: if (fire) begin
        if (!beat_last) begin
          if (kr_q == KW'(K - 1)) begin
            kr_d = '0;
            kc_d = kc_q + KW'(1);
          end else begin
            kr_d = kr_q + KW'(1);
          end
        end else begin
          kr_d = '0;
          if (!last_c) begin
            state_d = STEP;
            kc_d    = KW'(K - NS);
            adv     = 1'b1;
          end else if (!last_r) begin
            state_d = LOAD;
            kc_d    = '0;
            adv     = 1'b1;
          end else begin
            state_d = FIN;
            kc_d    = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            clr     = 1'b1;
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      kr_q    <= '0;
      kc_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      kr_q    <= kr_d;
      kc_q    <= kc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  logic signed [CW-1:0] row_s, col_s;
  logic                 oob;
  logic [ADDR_W-1:0]    lin;

  always_comb begin
    row_s = $signed(CW'(r)) * $signed(CW'(STRIDE)) + $signed(CW'(OFF - H)) + $signed(CW'(kr_q));
    col_s = $signed(CW'(c)) * $signed(CW'(STRIDE)) + $signed(CW'(OFF - H)) + $signed(CW'(kc_q));
    lin   = ADDR_W'($unsigned(row_s)) * ADDR_W'(IMG_W) + ADDR_W'($unsigned(col_s));
  end

`ifdef CONV_ZERO_PAD_EN
  assign oob = row_s[CW-1] || (row_s >= $signed(CW'(IMG_H))) ||
               col_s[CW-1] || (col_s >= $signed(CW'(IMG_W)));
`else
  assign oob = 1'b0;
`endif

  assign addr      = (addr_valid && !oob) ? lin : '0;
  assign addr_pad  = addr_valid && oob;
  assign win_first = addr_valid && (kr_q == '0) && (kc_q == kc_start);
  assign win_last  = addr_valid && beat_last;
  assign win_full  = (state_q == LOAD);
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_conv_window_addr_gen.sv
// Scoreboard bench: a loop-nest reference model queues every expected beat at start.
module tb_conv_window_addr_gen;

  localparam int W = 28, HI = 28, K = 3;
`ifdef CONV_ZERO_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  typedef struct packed {
    logic [9:0] addr;
    logic pad, first, last, full;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, addr_ready, start2, ready2;
  logic busy, done, addr_valid, addr_pad, win_first, win_last, win_full;
  logic busy2, done2, v2, pad2, first2, last2, full2;
  logic [9:0] addr, addr2;

  conv_window_addr_gen #(.IMG_W(W), .IMG_H(HI), .K(K), .STRIDE(1), .ADDR_W(10)) u_dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .addr_valid(addr_valid), .addr_ready(addr_ready), .addr(addr), .addr_pad(addr_pad),
    .win_first(win_first), .win_last(win_last), .win_full(win_full)
  );

  conv_window_addr_gen #(.IMG_W(W), .IMG_H(HI), .K(K), .STRIDE(2), .ADDR_W(10)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
    .addr_valid(v2), .addr_ready(ready2), .addr(addr2), .addr_pad(pad2),
    .win_first(first2), .win_last(last2), .win_full(full2)
  );

  beat_t q[$];
  beat_t q2[$];
  int n_run = 0, n_fail = 0;
  int exp_a[12];
  bit exp_p[12];
  int exp2_a[6];
  bit exp2_p[6];
  int total1, total2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic build(input int s, input bit sel);
    int h, off, ow, oh, cs, row, col, tmp;
    beat_t b;
    h   = (K - 1) / 2;
    off = PAD ? 0 : h;
    ow  = PAD ? (W + s - 1) / s : (W - K) / s + 1;
    oh  = PAD ? (HI + s - 1) / s : (HI - K) / s + 1;
    for (int r = 0; r < oh; r++)
      for (int c = 0; c < ow; c++) begin
        cs = (c == 0) ? 0 : K - s;
        for (int kc = cs; kc < K; kc++)
          for (int kr = 0; kr < K; kr++) begin
            row     = r * s + off - h + kr;
            col     = c * s + off - h + kc;
            b.pad   = PAD && (row < 0 || row >= HI || col < 0 || col >= W);
            tmp     = b.pad ? 0 : row * W + col;
            b.addr  = tmp[9:0];
            b.first = (kc == cs) && (kr == 0);
            b.last  = (kc == K - 1) && (kr == K - 1);
            b.full  = (c == 0);
            if (sel) q2.push_back(b); else q.push_back(b);
          end
      end
  endtask

  task automatic pulse_start();
    @(negedge clk); addr_ready = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("busy_after_start", 32'(busy), 1);
    chk("valid_after_start", 32'(addr_valid), 1);
  endtask

  // Consumes beats from u_dut until max_beats, optionally stalling the 6th beat
  // and pulsing a stray start once beat ms_start has transferred.
  task automatic run_scan(input int max_beats, input bit stall, input int ms_start, output int nb);
    int cyc, st;
    bit sp;
    beat_t e;
    nb = 0; cyc = 0; st = 0; sp = 0;
    while (nb < max_beats && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (ms_start >= 0 && nb == ms_start && !sp) begin start = 1'b1; sp = 1; end
      addr_ready = 1'b1;
      if (stall && nb == 5 && st < 5) begin
        addr_ready = 1'b0;
        st++;
        chk("stall_addr_hold", 32'(addr), exp_a[5]);
        chk("stall_valid_hold", 32'(addr_valid), 1);
      end
      if (addr_valid && addr_ready) begin
        n_run++;
        assert (q.size() > 0) else begin
          n_fail++;
          $error("FAIL extra_beat observed=%0d expected<=%0d", nb + 1, nb);
        end
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("beat", 32'({addr, addr_pad, win_first, win_last, win_full}), 32'(e));
        end
        if (nb < 12) begin
          chk("dir_addr", 32'(addr), exp_a[nb]);
          chk("dir_pad", 32'(addr_pad), 32'(exp_p[nb]));
        end
        nb++;
      end
    end
    start = 1'b0;
    chk("scan_no_timeout", nb, max_beats);
  endtask

  initial begin
    int nb, cyc;
    beat_t e;
`ifdef CONV_ZERO_PAD_EN
    exp_a  = '{0, 0, 0, 0, 0, 28, 0, 1, 29, 0, 2, 30};
    exp_p  = '{1, 1, 1, 1, 0, 0, 1, 0, 0, 1, 0, 0};
    exp2_a = '{0, 2, 30, 0, 3, 31};
    exp2_p = '{1, 0, 0, 1, 0, 0};
    total1 = 2520;
    total2 = 1218;
`else
    exp_a  = '{0, 28, 56, 1, 29, 57, 2, 30, 58, 3, 31, 59};
    exp_p  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    exp2_a = '{3, 31, 59, 4, 32, 60};
    exp2_p = '{0, 0, 0, 0, 0, 0};
    total1 = 2184;
    total2 = 1053;
`endif
    rst = 1'b0; start = 1'b0; addr_ready = 1'b0; start2 = 1'b0; ready2 = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({busy, done, addr_valid, addr_pad, win_first, win_last, win_full, addr}), 0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", 32'({busy, addr_valid}), 0);

    // Full scan with a consumer stall and a stray start while busy.
    build(1, 0);
    pulse_start();
    run_scan(total1, 1, 50, nb);
    @(negedge clk);
    chk("done_pulse", 32'(done), 1);
    chk("busy_fall", 32'(busy), 0);
    chk("queue_drained", q.size(), 0);
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 0);
    chk("idle_after_scan", 32'(addr_valid), 0);

    // Reset mid-scan, then restart from the first beat.
    q.delete();
    build(1, 0);
    pulse_start();
    run_scan(100, 0, -1, nb);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midscan_reset", 32'({busy, done, addr_valid, addr_pad, win_first, win_last, win_full, addr}), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_after_midscan_reset", 32'({busy, addr_valid}), 0);
    q.delete();
    build(1, 0);
    pulse_start();
    run_scan(12, 0, -1, nb);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    q.delete();

    // Stride 2 scan on the second instance.
    build(2, 1);
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    nb = 0; cyc = 0;
    while (!done2 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      ready2 = 1'b1;
      if (v2 && ready2) begin
        if (q2.size() > 0) begin
          e = q2.pop_front();
          chk("s2_beat", 32'({addr2, pad2, first2, last2, full2}), 32'(e));
        end
        if (nb >= 9 && nb < 15) begin
          chk("s2_win2_addr", 32'(addr2), exp2_a[nb - 9]);
          chk("s2_win2_pad", 32'(pad2), 32'(exp2_p[nb - 9]));
          chk("s2_win2_full", 32'(full2), 0);
        end
        nb++;
      end
    end
    chk("s2_total_beats", nb, total2);
    chk("s2_busy_fall", 32'(busy2), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
